// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: port IDs, word width and
// the default starvation threshold.
package dmem_arbiter_pkg;
   localparam int WORD_W               = 32;
   localparam int CNT_W                = 4;
   localparam int STARVE_LIMIT_DEFAULT = 4;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction
endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating count of consecutive cycles the debug port was denied, plus the
// threshold compare that lets it override the CPU.
module dmem_starve_ctr import dmem_arbiter_pkg::*; #(
   parameter int LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_req,
   input  logic d_gnt,
   output logic starved
);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] starve_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (d_gnt) begin
         starve_cnt <= '0;
      end else if (d_req && starve_cnt != CNT_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   assign starved = (starve_cnt >= LIMIT_C);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / debug) arbiter onto a single-ported data memory with
// one-cycle read latency; grants are combinational, responses are pipelined.
module dmem_arbiter import dmem_arbiter_pkg::*; #(
   parameter int ADDR_W       = 8,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [WORD_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [WORD_W-1:0] c_rdata,
   output logic              c_err,
   output logic              c_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_err,
   output logic              m_en,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [WORD_W-1:0] m_wdata,
   input  logic [WORD_W-1:0] m_rdata
);
   // Handshake: a port holds req and its fields stable until it sees gnt in
   // the same cycle; reads return rvalid exactly one cycle after that grant.
   logic              starved;
   logic              rsp_valid;
   logic              rsp_owner;
   logic [WORD_W-1:0] c_rdata_q;
   logic [WORD_W-1:0] d_rdata_q;

   dmem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk     (clk),
      .rst_n   (rst_n),
      .d_req   (d_req),
      .d_gnt   (d_gnt),
      .starved (starved)
   );

   always_comb begin
      c_gnt   = rst_n & c_req & ~(d_req & starved);
      d_gnt   = rst_n & d_req & (~c_req | starved);
      m_en    = c_gnt | d_gnt;
      m_we    = (c_gnt & c_we) | (d_gnt & d_we);
      m_addr  = '0;
      m_wdata = '0;
      if (d_gnt) begin
         m_addr  = {d_addr[ADDR_W-1:2], 2'b00};
         m_wdata = d_wdata;
      end else if (c_gnt) begin
         m_addr  = {c_addr[ADDR_W-1:2], 2'b00};
         m_wdata = c_wdata;
      end
      c_err   = c_gnt & is_misaligned(c_addr[1:0]);
      d_err   = d_gnt & is_misaligned(d_addr[1:0]);
      c_stall = c_req & ~c_gnt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_owner <= PORT_CPU;
      end else begin
         rsp_valid <= m_en & ~m_we;
         rsp_owner <= d_gnt ? PORT_DBG : PORT_CPU;
      end
   end

   // Gating with rst_n drops a read that was granted just before reset.
   assign c_rvalid = rst_n & rsp_valid & (rsp_owner == PORT_CPU);
   assign d_rvalid = rst_n & rsp_valid & (rsp_owner == PORT_DBG);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         c_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (c_rvalid) c_rdata_q <= m_rdata;
         if (d_rvalid) d_rdata_q <= m_rdata;
      end
   end

   assign c_rdata = c_rvalid ? m_rdata : c_rdata_q;
   assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for the grant/mux logic and
// hand-written sequences for latency, starvation, reset and alignment cases.
module tb_dmem_arbiter;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          c_req, c_we, d_req, d_we;
   logic [AW-1:0] c_addr, d_addr;
   logic [31:0]   c_wdata, d_wdata;
   logic          c_gnt, c_rvalid, c_err, c_stall;
   logic          d_gnt, d_rvalid, d_err;
   logic [31:0]   c_rdata, d_rdata;
   logic          m_en, m_we;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata, m_rdata;

   logic [31:0]   mem [64];
   int            n_vec = 0;
   int            n_err = 0;

   typedef struct {
      logic          c_req, c_we;
      logic [AW-1:0] c_addr;
      logic [31:0]   c_wdata;
      logic          d_req, d_we;
      logic [AW-1:0] d_addr;
      logic [31:0]   d_wdata;
      logic          e_c_gnt, e_d_gnt, e_m_we, e_c_err, e_d_err, e_c_stall;
      logic [AW-1:0] e_m_addr;
      logic [31:0]   e_m_wdata;
   } vec_t;

   vec_t vecs [10];

   dmem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
      .c_stall(c_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata)
   );

   // clock and memory model (one-cycle read latency)
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (m_en && m_we)  mem[m_addr[AW-1:2]] <= m_wdata;
      if (m_en && !m_we) m_rdata <= mem[m_addr[AW-1:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   task automatic idle;
      c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
   endtask

   task automatic drive_c(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
      c_req = 1; c_we = we; c_addr = a; c_wdata = wd;
   endtask

   task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
      d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
   endtask

   task automatic do_reset;
      step; rst_n = 0; idle;
      step; step;
      rst_n = 1;
   endtask

   function automatic vec_t mk(
      input logic cr, cw, input logic [AW-1:0] ca, input logic [31:0] cd,
      input logic dr, dw, input logic [AW-1:0] da, input logic [31:0] dd,
      input logic gc, gd, we, ec, ed, st,
      input logic [AW-1:0] ma, input logic [31:0] mw);
      vec_t v;
      v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
      v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
      v.e_c_gnt = gc; v.e_d_gnt = gd; v.e_m_we = we;
      v.e_c_err = ec; v.e_d_err = ed; v.e_c_stall = st;
      v.e_m_addr = ma; v.e_m_wdata = mw;
      return v;
   endfunction

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      mem[0] = 32'd5;
      mem[3] = 32'hDEADBEEF;
      m_rdata = '0;
      rst_n = 0;
      idle;

      //            cr cw caddr  cwdata        dr dw daddr  dwdata        gc gd we ec ed st maddr  mwdata
      vecs[0] = mk(0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 0, 8'h00, 32'h0);
      vecs[1] = mk(1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 0, 0, 0, 0, 8'h10, 32'h0);
      vecs[2] = mk(1, 1, 8'h21, 32'hA5A5A5A5, 0, 0, 8'h00, 32'h0,        1, 0, 1, 1, 0, 0, 8'h20, 32'hA5A5A5A5);
      vecs[3] = mk(0, 0, 8'h00, 32'h0,        1, 0, 8'h30, 32'h0,        0, 1, 0, 0, 0, 0, 8'h30, 32'h0);
      vecs[4] = mk(0, 0, 8'h00, 32'h0,        1, 1, 8'h33, 32'h0BADF00D, 0, 1, 1, 0, 1, 0, 8'h30, 32'h0BADF00D);
      vecs[5] = mk(1, 0, 8'h04, 32'h0,        1, 0, 8'h08, 32'h0,        1, 0, 0, 0, 0, 0, 8'h04, 32'h0);
      vecs[6] = mk(1, 0, 8'h04, 32'h0,        1, 0, 8'h08, 32'h0,        1, 0, 0, 0, 0, 0, 8'h04, 32'h0);
      vecs[7] = mk(0, 0, 8'h00, 32'h0,        1, 0, 8'h08, 32'h0,        0, 1, 0, 0, 0, 0, 8'h08, 32'h0);
      vecs[8] = mk(1, 1, 8'h05, 32'h11111111, 1, 0, 8'h08, 32'h0,        1, 0, 1, 1, 0, 0, 8'h04, 32'h11111111);
      vecs[9] = mk(1, 0, 8'h0C, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 0, 0, 0, 0, 8'h0C, 32'h0);

      // reset state
      step; step;
      #1;
      chk("rst_m_en", 32'(m_en), 32'h0);
      chk("rst_c_rvalid", 32'(c_rvalid), 32'h0);
      chk("rst_starve_cnt", 32'(dut.u_starve.starve_cnt), 32'h0);
      rst_n = 1;

      // CPU-only read, latency 1, then rdata held
      step; drive_c(0, 8'h00, 32'h0); #1;
      chk("a_c_gnt", 32'(c_gnt), 32'h1);
      chk("a_m_en", 32'(m_en), 32'h1);
      step; idle; #1;
      chk("a_c_rvalid", 32'(c_rvalid), 32'h1);
      chk("a_c_rdata", c_rdata, 32'd5);
      chk("a_d_rvalid", 32'(d_rvalid), 32'h0);
      step; #1;
      chk("a_rvalid_drop", 32'(c_rvalid), 32'h0);
      chk("a_rdata_hold", c_rdata, 32'd5);

      // reset arriving the cycle after a granted read
      step; drive_c(0, 8'h00, 32'h0); drive_d(0, 8'h08, 32'h0); #1;
      chk("e_c_gnt", 32'(c_gnt), 32'h1);
      step; rst_n = 0; #1;
      chk("e_c_rvalid", 32'(c_rvalid), 32'h0);
      chk("e_m_en", 32'(m_en), 32'h0);
      chk("e_gnts", {30'h0, c_gnt, d_gnt}, 32'h0);
      step; #1;
      chk("e_starve_cnt", 32'(dut.u_starve.starve_cnt), 32'h0);
      chk("e_c_rdata", c_rdata, 32'h0);
      chk("e_c_rvalid2", 32'(c_rvalid), 32'h0);
      step; rst_n = 1; d_req = 0; #1;
      chk("e_first_gnt", 32'(c_gnt), 32'h1);
      step; idle; #1;
      chk("e_post_rvalid", 32'(c_rvalid), 32'h1);
      chk("e_post_rdata", c_rdata, 32'd5);

      // vector table: grant priority, muxing, alignment, starvation hold
      do_reset;
      for (int i = 0; i < 10; i++) begin
         step;
         c_req = vecs[i].c_req; c_we = vecs[i].c_we;
         c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
         d_req = vecs[i].d_req; d_we = vecs[i].d_we;
         d_addr = vecs[i].d_addr; d_wdata = vecs[i].d_wdata;
         #1;
         chk($sformatf("v%0d_c_gnt", i), 32'(c_gnt), 32'(vecs[i].e_c_gnt));
         chk($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(vecs[i].e_d_gnt));
         chk($sformatf("v%0d_m_en", i), 32'(m_en), 32'(vecs[i].e_c_gnt | vecs[i].e_d_gnt));
         chk($sformatf("v%0d_m_we", i), 32'(m_we), 32'(vecs[i].e_m_we));
         chk($sformatf("v%0d_m_addr", i), 32'(m_addr), 32'(vecs[i].e_m_addr));
         chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].e_m_wdata);
         chk($sformatf("v%0d_c_err", i), 32'(c_err), 32'(vecs[i].e_c_err));
         chk($sformatf("v%0d_d_err", i), 32'(d_err), 32'(vecs[i].e_d_err));
         chk($sformatf("v%0d_c_stall", i), 32'(c_stall), 32'(vecs[i].e_c_stall));
      end
      step; idle; #1;
      chk("tbl_starve_hold", 32'(dut.u_starve.starve_cnt), 32'h1);

      // starvation: debug wins on the 5th contended cycle
      do_reset;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         step; drive_c(0, 8'h40, 32'h0); drive_d(0, 8'h44, 32'h0); #1;
         if (cyc <= 4) begin
            chk($sformatf("b%0d_d_gnt", cyc), 32'(d_gnt), 32'h0);
            chk($sformatf("b%0d_c_gnt", cyc), 32'(c_gnt), 32'h1);
            chk($sformatf("b%0d_d_rvalid", cyc), 32'(d_rvalid), 32'h0);
         end else if (cyc == 5) begin
            chk("b5_d_gnt", 32'(d_gnt), 32'h1);
            chk("b5_c_gnt", 32'(c_gnt), 32'h0);
            chk("b5_c_stall", 32'(c_stall), 32'h1);
         end else begin
            chk("b6_starve_cnt", 32'(dut.u_starve.starve_cnt), 32'h0);
            chk("b6_c_gnt", 32'(c_gnt), 32'h1);
            chk("b6_d_rvalid", 32'(d_rvalid), 32'h1);
            chk("b6_c_rvalid", 32'(c_rvalid), 32'h0);
         end
      end

      // write then debug read of the same word
      step; idle; drive_c(1, 8'h08, 32'h12345678); #1;
      chk("c_wr_m_we", 32'(m_we), 32'h1);
      chk("c_wr_m_addr", 32'(m_addr), 32'h08);
      step; idle; drive_d(0, 8'h08, 32'h0); #1;
      chk("c_rd_d_gnt", 32'(d_gnt), 32'h1);
      chk("c_rd_m_we", 32'(m_we), 32'h0);
      step; idle; #1;
      chk("c_d_rvalid", 32'(d_rvalid), 32'h1);
      chk("c_d_rdata", d_rdata, 32'h12345678);
      chk("c_c_rvalid", 32'(c_rvalid), 32'h0);

      // misaligned CPU read
      step; drive_c(0, 8'h0D, 32'h0); #1;
      chk("d_m_addr", 32'(m_addr), 32'h0C);
      chk("d_c_err", 32'(c_err), 32'h1);
      step; idle; #1;
      chk("d_c_err_pulse", 32'(c_err), 32'h0);
      chk("d_c_rvalid", 32'(c_rvalid), 32'h1);
      chk("d_c_rdata", c_rdata, 32'hDEADBEEF);
      chk("d_d_rdata_held", d_rdata, 32'h12345678);

      // simultaneous requests, then CPU drops
      do_reset;
      step; drive_c(0, 8'h00, 32'h0); drive_d(0, 8'h0C, 32'h0); #1;
      chk("f_c_gnt", 32'(c_gnt), 32'h1);
      chk("f_d_gnt", 32'(d_gnt), 32'h0);
      step; c_req = 0; #1;
      chk("f_d_gnt2", 32'(d_gnt), 32'h1);
      chk("f_c_rvalid", 32'(c_rvalid), 32'h1);
      step; idle; #1;
      chk("f_d_rvalid", 32'(d_rvalid), 32'h1);
      chk("f_d_rdata", d_rdata, 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Clocking SHALL be one clock, `clk`; reset SHALL be `rst_n`, synchronous, active-low.
REQ-002 Parameter ADDR_W, default 8, SHALL set the byte-address width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive denied cycles after which the debug port wins (legal range 1..15).
REQ-004 Port `clk` SHALL be input, 1 bit: clock, all state updates on its rising edge.
REQ-005 Port `rst_n` SHALL be input, 1 bit: synchronous active-low reset.
REQ-006 Ports `c_req`, `c_we` SHALL be inputs, 1 bit each: CPU MEM-stage access request and write enable.
REQ-007 Ports `c_addr` (ADDR_W) and `c_wdata` (32) SHALL be inputs: CPU byte address and write word.
REQ-008 Ports `c_gnt`, `c_rvalid`, `c_err` SHALL be outputs, 1 bit each; `c_rdata` SHALL be an output, 32 bits.
REQ-009 Port `c_stall` SHALL be an output, 1 bit: CPU pipeline freeze.
REQ-010 Debug port signals `d_req`, `d_we`, `d_addr`, `d_wdata`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_err` SHALL mirror the CPU port in direction and width.
REQ-011 Memory-side outputs SHALL be `m_en` (1), `m_we` (1), `m_addr` (ADDR_W) and `m_wdata` (32); input `m_rdata` (32) SHALL be valid one cycle after `m_en`.

Function
REQ-012 At most one grant SHALL be asserted per cycle; a grant SHALL be combinational from the same-cycle requests and state.
REQ-013 Priority: CPU wins by default; debug wins when `c_req`=0, or when starve_cnt>=STARVE_LIMIT.
REQ-014 starve_cnt (4 bits) SHALL increment when `d_req`=1 and `d_gnt`=0, clear on `d_gnt`, hold when `d_req`=0, and saturate at 15.
REQ-015 On a grant: `m_en`=1; `m_we`, `m_wdata` and `m_addr` come from the granted port; `m_addr` has bits[1:0] forced to 0.
REQ-016 On a grant with addr[1:0]!=0, the access SHALL still proceed word-aligned, and that port's `err` SHALL pulse 1 cycle coincident with the grant.
REQ-017 Reads SHALL have a latency of 1: a granted read in cycle N gives `rvalid`=1 in N+1 on the same port only, with `rdata`=`m_rdata`.
REQ-018 Writes SHALL produce no `rvalid`.
REQ-019 `rdata` SHALL be held between read responses.
REQ-020 A one-bit response-owner register SHALL record which port owns the in-flight read.
REQ-021 Back-to-back grants every cycle SHALL be supported: responses are pipelined and never dropped.
REQ-022 `c_stall` SHALL equal `c_req & ~c_gnt`; a requester SHALL hold its request fields stable until granted.
REQ-023 With no request, `m_en`=0, `m_we`=0, and all grants are 0.
REQ-024 A request deasserted before its grant SHALL be legal and SHALL leave no side effect, except that starve_cnt holds.

Reset
REQ-025 While `rst_n`=0 at a clock edge, these SHALL be 0: starve_cnt, response-owner valid, `c_rvalid`, `d_rvalid`, `c_rdata`, `d_rdata`.
REQ-026 While `rst_n`=0, grants, `m_en` and `m_we` SHALL be forced to 0.
REQ-027 A read granted in the cycle before reset asserts SHALL have its `rvalid` suppressed.
REQ-028 The first grant after release SHALL be possible in the first cycle with `rst_n`=1.

Structure
REQ-029 A shared package SHALL hold the port-ID constants (PORT_CPU=0, PORT_DBG=1), the STARVE_LIMIT default and the word width 32.
REQ-030 One sub-module, `dmem_starve_ctr`, SHALL hold the saturating starvation counter and its threshold compare; the rest stays flat.

Verification
REQ-031 Scenario, CPU only: CPU read @0x00 with `m_rdata`=5 -> `c_gnt`=1 at cycle N; `c_rvalid`=1 and `c_rdata`=5 at N+1; `d_rvalid`=0.
REQ-032 Scenario, CPU requests every cycle with `d_req` held: `d_gnt` SHALL assert exactly on the 5th cycle (STARVE_LIMIT=4); `c_stall`=1 that cycle; starve_cnt=0 the cycle after.
REQ-033 Scenario, pipelining: CPU write 0x12345678 @0x08, then debug read @0x08 -> `m_we` pulses once, then `d_rvalid` with the memory model's 0x12345678.
REQ-034 Scenario, alignment: CPU read @0x0D -> `m_addr`=0x0C; `c_err` pulses 1 cycle; `c_rvalid` the next cycle.
REQ-035 Scenario, reset mid-read: read granted at N, `rst_n`=0 at N+1 -> `c_rvalid`=0, `m_en`=0 during reset, starve_cnt=0.
REQ-036 Scenario, simultaneous requests both ports, starve_cnt=0 -> CPU granted; the debug port is granted the following cycle if the CPU drops its request.
